// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared owner encoding, access sizes and byte-enable helper
//               for the unified memory port and its lane-alignment logic.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Sizes 2 and 3 both mean a full word.
  function automatic logic [3:0] be_from_sz(input logic [1:0] sz, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Byte-enable generation, write-data lane replication and
//               misalignment detection for byte/half/word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_sz,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);

  assign o_be       = be_from_sz(i_sz, i_addr_lo);
  assign o_misalign = ((i_sz == SZ_HALF) && i_addr_lo[0]) ||
                      (i_sz[1] && (i_addr_lo != 2'b00));

  // Each byte lane picks its source byte so the memory can use the enables alone.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign o_wdata[i*8 +: 8] = (i_sz == SZ_BYTE) ? i_wdata[7:0] :
                               (i_sz == SZ_HALF) ? i_wdata[(i%2)*8 +: 8] :
                                                   i_wdata[i*8 +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and data
//               access; data has priority, fetch is protected from starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_r,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_busy,
  input  logic        data_r,
  input  logic        data_w,
  input  logic [1:0]  data_sz,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_busy,
  output logic        data_misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  owner_t      r_owner;
  owner_t      w_owner_nxt;
  logic        r_if_pend;
  logic [29:0] r_if_addr;
  logic        r_d_pend;
  logic        r_d_we;
  logic [3:0]  r_d_be;
  logic [29:0] r_d_addr;
  logic [31:0] r_d_wdata;
  logic [3:0]  r_starve;
  logic [3:0]  w_starve_nxt;
  logic [31:0] r_if_hold;
  logic [31:0] r_d_hold;
  logic        r_misalign;

  logic        w_ack_if, w_ack_d;
  logic        w_if_busy, w_d_busy;
  logic        w_if_take, w_d_req, w_d_take, w_d_misalign_ev;
  logic        w_if_pend_nxt, w_d_pend_nxt;
  logic        w_arb;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic        w_misalign;
  logic        w_unused;

  assign w_unused = ^if_addr[1:0];

  mem_lane_align u_align (
    .i_sz       (data_sz),
    .i_addr_lo  (data_addr[1:0]),
    .i_wdata    (data_wdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata_rep),
    .o_misalign (w_misalign)
  );

  assign w_ack_if  = (r_owner == OWN_IF)   && mem_ack;
  assign w_ack_d   = (r_owner == OWN_DATA) && mem_ack;
  assign w_if_busy = r_if_pend && !w_ack_if;
  assign w_d_busy  = r_d_pend  && !w_ack_d;

  // A port may accept its next op in the very cycle the previous one completes.
  assign w_if_take       = if_r && !w_if_busy;
  assign w_d_req         = data_r || data_w;
  assign w_d_take        = w_d_req && !w_d_busy && !w_misalign;
  assign w_d_misalign_ev = w_d_req && !w_d_busy &&  w_misalign;

  assign w_if_pend_nxt = w_if_take || (r_if_pend && !w_ack_if);
  assign w_d_pend_nxt  = w_d_take  || (r_d_pend  && !w_ack_d);
  assign w_arb         = (r_owner == OWN_NONE) || mem_ack;

  always_comb begin
    w_owner_nxt  = r_owner;
    w_starve_nxt = r_starve;
    if (w_arb) begin
      if (w_d_pend_nxt && !((r_starve == c_starve_limit) && w_if_pend_nxt))
        w_owner_nxt = OWN_DATA;
      else if (w_if_pend_nxt)
        w_owner_nxt = OWN_IF;
      else
        w_owner_nxt = OWN_NONE;
    end
    if (!w_if_pend_nxt)
      w_starve_nxt = 4'd0;
    else if (w_arb && (w_owner_nxt == OWN_IF))
      w_starve_nxt = 4'd0;
    else if (w_arb && (w_owner_nxt == OWN_DATA) && (r_starve != c_starve_limit))
      w_starve_nxt = r_starve + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= OWN_NONE;
      r_if_pend  <= 1'b0;
      r_if_addr  <= '0;
      r_d_pend   <= 1'b0;
      r_d_we     <= 1'b0;
      r_d_be     <= '0;
      r_d_addr   <= '0;
      r_d_wdata  <= '0;
      r_starve   <= '0;
      r_if_hold  <= '0;
      r_d_hold   <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_starve   <= w_starve_nxt;
      r_if_pend  <= w_if_pend_nxt;
      r_d_pend   <= w_d_pend_nxt;
      r_misalign <= w_d_misalign_ev;
      if (w_if_take)
        r_if_addr <= if_addr[31:2];
      if (w_d_take) begin
        r_d_we    <= data_w;
        r_d_be    <= w_be;
        r_d_addr  <= data_addr[31:2];
        r_d_wdata <= w_wdata_rep;
      end
      if (w_ack_if)
        r_if_hold <= mem_rdata;
      if (w_ack_d)
        r_d_hold  <= mem_rdata;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_owner)
      OWN_IF: begin
        mem_req  = 1'b1;
        mem_be   = 4'b1111;
        mem_addr = r_if_addr;
      end
      OWN_DATA: begin
        mem_req   = 1'b1;
        mem_we    = r_d_we;
        mem_be    = r_d_be;
        mem_addr  = r_d_addr;
        mem_wdata = r_d_wdata;
      end
      default: ;
    endcase
  end

  assign if_busy       = w_if_busy;
  assign data_busy     = w_d_busy;
  assign data_misalign = r_misalign;
  assign if_rdata      = (r_owner == OWN_IF)   ? mem_rdata : r_if_hold;
  assign data_rdata    = (r_owner == OWN_DATA) ? mem_rdata : r_d_hold;

endmodule
`default_nettype wire
